// File: rtl/dezigzag_buffer.sv
// Ping-pong 2x64 reorder buffer: takes 8x8 coefficient blocks in JPEG zigzag order
// and replays them in raster order with valid/ready handshakes on both sides.
module dezigzag_buffer #(
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          dout_sob,
    output logic          dout_eob
);

    // Raster index of the coefficient at zigzag step k.
    function automatic logic [5:0] zz_map(input logic [5:0] k);
        case (k)
            6'd0:  zz_map = 6'd0;   6'd1:  zz_map = 6'd1;   6'd2:  zz_map = 6'd8;   6'd3:  zz_map = 6'd16;
            6'd4:  zz_map = 6'd9;   6'd5:  zz_map = 6'd2;   6'd6:  zz_map = 6'd3;   6'd7:  zz_map = 6'd10;
            6'd8:  zz_map = 6'd17;  6'd9:  zz_map = 6'd24;  6'd10: zz_map = 6'd32;  6'd11: zz_map = 6'd25;
            6'd12: zz_map = 6'd18;  6'd13: zz_map = 6'd11;  6'd14: zz_map = 6'd4;   6'd15: zz_map = 6'd5;
            6'd16: zz_map = 6'd12;  6'd17: zz_map = 6'd19;  6'd18: zz_map = 6'd26;  6'd19: zz_map = 6'd33;
            6'd20: zz_map = 6'd40;  6'd21: zz_map = 6'd48;  6'd22: zz_map = 6'd41;  6'd23: zz_map = 6'd34;
            6'd24: zz_map = 6'd27;  6'd25: zz_map = 6'd20;  6'd26: zz_map = 6'd13;  6'd27: zz_map = 6'd6;
            6'd28: zz_map = 6'd7;   6'd29: zz_map = 6'd14;  6'd30: zz_map = 6'd21;  6'd31: zz_map = 6'd28;
            6'd32: zz_map = 6'd35;  6'd33: zz_map = 6'd42;  6'd34: zz_map = 6'd49;  6'd35: zz_map = 6'd56;
            6'd36: zz_map = 6'd57;  6'd37: zz_map = 6'd50;  6'd38: zz_map = 6'd43;  6'd39: zz_map = 6'd36;
            6'd40: zz_map = 6'd29;  6'd41: zz_map = 6'd22;  6'd42: zz_map = 6'd15;  6'd43: zz_map = 6'd23;
            6'd44: zz_map = 6'd30;  6'd45: zz_map = 6'd37;  6'd46: zz_map = 6'd44;  6'd47: zz_map = 6'd51;
            6'd48: zz_map = 6'd58;  6'd49: zz_map = 6'd59;  6'd50: zz_map = 6'd52;  6'd51: zz_map = 6'd45;
            6'd52: zz_map = 6'd38;  6'd53: zz_map = 6'd31;  6'd54: zz_map = 6'd39;  6'd55: zz_map = 6'd46;
            6'd56: zz_map = 6'd53;  6'd57: zz_map = 6'd60;  6'd58: zz_map = 6'd61;  6'd59: zz_map = 6'd54;
            6'd60: zz_map = 6'd47;  6'd61: zz_map = 6'd55;  6'd62: zz_map = 6'd62;  6'd63: zz_map = 6'd63;
            default: zz_map = 6'd63;
        endcase
    endfunction

    logic [DW-1:0] mem_r [0:127];
    logic [1:0]    bank_full_r;
    logic          wr_bank_r;
    logic          rd_bank_r;
    logic [5:0]    wr_cnt_r;
    logic [5:0]    rd_cnt_r;
    logic          wr_en_s;
    logic          load_s;

    // Handshake qualifiers; ena gates both sides so a frozen buffer completes nothing.
    always_comb begin
        din_ready = ena & ~bank_full_r[wr_bank_r];
        wr_en_s   = din_valid & din_ready;
        load_s    = ena & bank_full_r[rd_bank_r] & (~dout_valid | dout_ready);
    end

    // Scatter incoming zigzag samples to their raster slot in the write bank.
    always_ff @(posedge clk) begin
        if (!rst && wr_en_s) begin
            mem_r[{wr_bank_r, zz_map(wr_cnt_r)}] <= din;
        end
    end

    // Bank bookkeeping and the registered raster-order output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_full_r <= 2'b00;
            wr_bank_r   <= 1'b0;
            rd_bank_r   <= 1'b0;
            wr_cnt_r    <= 6'd0;
            rd_cnt_r    <= 6'd0;
            dout        <= '0;
            dout_valid  <= 1'b0;
            dout_sob    <= 1'b0;
            dout_eob    <= 1'b0;
        end else if (ena) begin
            if (wr_en_s) begin
                wr_cnt_r <= wr_cnt_r + 6'd1;
                if (wr_cnt_r == 6'd63) begin
                    bank_full_r[wr_bank_r] <= 1'b1;
                    wr_bank_r              <= ~wr_bank_r;
                end
            end
            // Reader only ever clears the bank it drains, which the writer cannot be filling.
            if (load_s) begin
                dout       <= mem_r[{rd_bank_r, rd_cnt_r}];
                dout_valid <= 1'b1;
                dout_sob   <= (rd_cnt_r == 6'd0);
                dout_eob   <= (rd_cnt_r == 6'd63);
                rd_cnt_r   <= rd_cnt_r + 6'd1;
                if (rd_cnt_r == 6'd63) begin
                    bank_full_r[rd_bank_r] <= 1'b0;
                    rd_bank_r              <= ~rd_bank_r;
                end
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
                dout_sob   <= 1'b0;
                dout_eob   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dezigzag_buffer.sv
// Randomised bench for dezigzag_buffer; the reference builds the zigzag walk from
// the anti-diagonal rule and reorders whole accepted blocks into an expected queue.
module tb_dezigzag_buffer;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst, ena, din_valid, din_ready, dout_valid, dout_ready, dout_sob, dout_eob;
    logic [DW-1:0] din, dout;

    always #5 clk = ~clk;

    dezigzag_buffer #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .ena(ena), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_sob(dout_sob), .dout_eob(dout_eob)
    );

    typedef struct { logic [DW-1:0] val; int r; } exp_t;

    int            errors = 0;
    int            checks = 0;
    int            zz_tab [64];
    exp_t          exp_q [$];
    logic [DW-1:0] blk [64];
    int            blk_n = 0;
    int            cyc = 0;
    logic          s_din_ready = 1'b0, s_dout_valid = 1'b0, s_sob = 1'b0, s_eob = 1'b0;
    logic [DW-1:0] s_dout = '0;
    logic          p_hold = 1'b0, p_sob = 1'b0, p_eob = 1'b0;
    logic [DW-1:0] p_dout = '0;
    logic          in_fire = 1'b0, out_fire = 1'b0, exp_ok = 1'b0;
    exp_t          exp_e;

    // Zigzag walk: anti-diagonal s=row+col, even diagonals run bottom-left to top-right.
    function automatic void build_zz();
        int k = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int row = hi; row >= lo; row--) begin zz_tab[k] = 8 * row + (s - row); k++; end
            end else begin
                for (int row = lo; row <= hi; row++) begin zz_tab[k] = 8 * row + (s - row); k++; end
            end
        end
    endfunction

    task automatic step(input logic e, input logic dv, input logic [DW-1:0] d, input logic dr);
        logic [DW-1:0] ras [64];
        @(negedge clk);
        p_hold = s_dout_valid && !out_fire;
        p_dout = s_dout; p_sob = s_sob; p_eob = s_eob;
        ena = e; din_valid = dv; din = d; dout_ready = dr;
        #1;
        s_din_ready = din_ready; s_dout_valid = dout_valid; s_dout = dout;
        s_sob = dout_sob; s_eob = dout_eob;
        in_fire  = dv && din_ready;
        out_fire = e && dout_valid && dr;
        exp_ok = 1'b1;
        if (out_fire) begin
            if (exp_q.size() == 0) exp_ok = 1'b0;
            else exp_e = exp_q.pop_front();
        end
        if (in_fire) begin
            blk[blk_n] = d;
            blk_n++;
            if (blk_n == 64) begin
                for (int k = 0; k < 64; k++) ras[zz_tab[k]] = blk[k];
                for (int r = 0; r < 64; r++) exp_q.push_back('{ras[r], r});
                blk_n = 0;
            end
        end
        cyc++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; ena = 1'b1; din_valid = 1'b0; dout_ready = 1'b0; din = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        blk_n = 0;
        s_dout_valid = 1'b0; out_fire = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", dout_valid); end
        checks++; if (dout !== '0) begin errors++; $display("FAIL rst_dout: got %0d want 0", dout); end
        checks++; if (dout_sob !== 1'b0 || dout_eob !== 1'b0) begin errors++; $display("FAIL rst_sob_eob: got %b%b want 00", dout_sob, dout_eob); end
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", din_ready); end
        ena = 1'b0; #1;
        checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL ena0_ready: got %b want 0", din_ready); end
        ena = 1'b1;
    endtask

    task automatic test_single_block();
        int k = 0, outs = 0, sobs = 0, eobs = 0, first_v = -1, last_acc = -1;
        for (int i = 0; i < 300 && outs < 64; i++) begin
            step(1'b1, k < 64, DW'(k), 1'b1);
            if (in_fire) begin last_acc = cyc; k++; end
            if (s_dout_valid && first_v < 0) first_v = cyc;
            if (out_fire) begin
                checks++;
                if (!exp_ok || s_dout !== exp_e.val || s_sob !== (exp_e.r == 0) || s_eob !== (exp_e.r == 63)) begin
                    errors++; $display("FAIL t1_data: got dout=%0d sob=%b eob=%b want dout=%0d r=%0d queued=%b", s_dout, s_sob, s_eob, exp_e.val, exp_e.r, exp_ok);
                end
                if (outs == 8)  begin checks++; if (s_dout !== 12'd2)  begin errors++; $display("FAIL t1_r8: got %0d want 2", s_dout); end end
                if (outs == 16) begin checks++; if (s_dout !== 12'd3)  begin errors++; $display("FAIL t1_r16: got %0d want 3", s_dout); end end
                if (outs == 63) begin checks++; if (s_dout !== 12'd63) begin errors++; $display("FAIL t1_r63: got %0d want 63", s_dout); end end
                sobs += int'(s_sob); eobs += int'(s_eob); outs++;
            end
        end
        checks++; if (outs != 64) begin errors++; $display("FAIL t1_count: got %0d want 64", outs); end
        checks++; if (first_v != last_acc + 2) begin errors++; $display("FAIL t1_latency: got valid at %0d want %0d", first_v, last_acc + 2); end
        checks++; if (sobs != 1 || eobs != 1) begin errors++; $display("FAIL t1_marks: got sob=%0d eob=%0d want 1 1", sobs, eobs); end
    endtask

    task automatic test_back_to_back();
        int sent = 0, outs = 0, low = 0, gaps = 0;
        logic started = 1'b0, dv;
        for (int i = 0; i < 600 && outs < 192; i++) begin
            dv = (sent < 192);
            step(1'b1, dv, DW'($urandom), 1'b1);
            if (in_fire) sent++;
            if (dv && !s_din_ready) low++;
            if (started && !s_dout_valid && outs < 192) gaps++;
            if (s_dout_valid) started = 1'b1;
            if (out_fire) begin
                checks++;
                if (!exp_ok || s_dout !== exp_e.val || s_sob !== (exp_e.r == 0) || s_eob !== (exp_e.r == 63)) begin
                    errors++; $display("FAIL t2_data: got dout=%0d sob=%b eob=%b want dout=%0d r=%0d queued=%b", s_dout, s_sob, s_eob, exp_e.val, exp_e.r, exp_ok);
                end
                outs++;
            end
        end
        checks++; if (low != 0) begin errors++; $display("FAIL t2_ready_drop: got %0d low cycles want 0", low); end
        checks++; if (gaps != 0) begin errors++; $display("FAIL t2_bubbles: got %0d want 0", gaps); end
        checks++; if (outs != 192 || exp_q.size() != 0) begin errors++; $display("FAIL t2_count: got %0d left=%0d want 192 0", outs, exp_q.size()); end
    endtask

    task automatic test_backpressure();
        int acc = 0, outs = 0;
        for (int i = 0; i < 400; i++) begin
            step(1'b1, 1'b1, DW'($urandom), 1'b0);
            if (in_fire) acc++;
            if (!s_din_ready) break;
        end
        checks++; if (acc != 128) begin errors++; $display("FAIL t3_accepts: got %0d want 128", acc); end
        checks++;
        if (exp_q.size() == 0 || s_dout_valid !== 1'b1 || s_dout !== exp_q[0].val || s_sob !== 1'b1) begin
            errors++; $display("FAIL t3_head: got valid=%b dout=%0d sob=%b", s_dout_valid, s_dout, s_sob);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            if (p_hold) begin
                checks++;
                if (s_dout_valid !== 1'b1 || s_dout !== p_dout || s_sob !== p_sob || s_eob !== p_eob) begin
                    errors++; $display("FAIL t3_hold: got %0d want %0d", s_dout, p_dout);
                end
            end
        end
        for (int i = 0; i < 400 && outs < 128; i++) begin
            step(1'b1, 1'b0, '0, 1'b1);
            if (out_fire) begin
                checks++;
                if (!exp_ok || s_dout !== exp_e.val || s_sob !== (exp_e.r == 0) || s_eob !== (exp_e.r == 63)) begin
                    errors++; $display("FAIL t3_data: got dout=%0d want dout=%0d r=%0d queued=%b", s_dout, exp_e.val, exp_e.r, exp_ok);
                end
                if (outs < 64) begin
                    checks++;
                    if (s_din_ready !== (exp_e.r == 63)) begin errors++; $display("FAIL t3_reopen: got din_ready=%b at r=%0d", s_din_ready, exp_e.r); end
                end
                outs++;
            end
        end
        checks++; if (outs != 128 || exp_q.size() != 0) begin errors++; $display("FAIL t3_count: got %0d left=%0d want 128 0", outs, exp_q.size()); end
    endtask

    task automatic test_random();
        int sent = 0, outs = 0, bad_hold = 0;
        for (int i = 0; i < 8000 && outs < 1280; i++) begin
            step(1'b1, (sent < 1280) && ($urandom_range(0, 1) == 1), DW'($urandom), $urandom_range(0, 1) == 1);
            if (in_fire) sent++;
            if (p_hold) begin
                checks++;
                if (s_dout_valid !== 1'b1 || s_dout !== p_dout || s_sob !== p_sob || s_eob !== p_eob) begin
                    errors++; bad_hold++;
                    if (bad_hold < 5) $display("FAIL t4_hold: got %0d/%b%b want %0d/%b%b", s_dout, s_sob, s_eob, p_dout, p_sob, p_eob);
                end
            end
            if (out_fire) begin
                checks++;
                if (!exp_ok || s_dout !== exp_e.val || s_sob !== (exp_e.r == 0) || s_eob !== (exp_e.r == 63)) begin
                    errors++; $display("FAIL t4_data: got dout=%0d sob=%b eob=%b want dout=%0d r=%0d queued=%b", s_dout, s_sob, s_eob, exp_e.val, exp_e.r, exp_ok);
                end
                outs++;
            end
        end
        checks++; if (outs != 1280 || exp_q.size() != 0) begin errors++; $display("FAIL t4_count: got %0d left=%0d want 1280 0", outs, exp_q.size()); end
    endtask

    task automatic test_mid_reset();
        int sent = 0, outs = 0, extra = 0;
        for (int i = 0; i < 300 && sent < 94; i++) begin
            step(1'b1, 1'b1, DW'($urandom), 1'b0);
            if (in_fire) sent++;
        end
        apply_reset();
        #1;
        checks++; if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin errors++; $display("FAIL t5_after_rst: got valid=%b ready=%b want 0 1", dout_valid, din_ready); end
        sent = 0;
        for (int i = 0; i < 300 && outs < 64; i++) begin
            step(1'b1, sent < 64, DW'(100 + sent), 1'b1);
            if (in_fire) sent++;
            if (out_fire) begin
                checks++;
                if (!exp_ok || s_dout !== exp_e.val || s_sob !== (exp_e.r == 0) || s_eob !== (exp_e.r == 63)) begin
                    errors++; $display("FAIL t5_data: got dout=%0d want dout=%0d r=%0d queued=%b", s_dout, exp_e.val, exp_e.r, exp_ok);
                end
                outs++;
            end
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, '0, 1'b1);
            if (s_dout_valid) extra++;
        end
        checks++; if (outs != 64 || extra != 0) begin errors++; $display("FAIL t5_count: got %0d extra=%0d want 64 0", outs, extra); end
    endtask

    task automatic test_enable_freeze();
        int sent = 0, outs = 0, frozen_acc = 0;
        for (int i = 0; i < 800 && outs < 128; i++) begin
            if (sent == 84 && frozen_acc == 0) begin
                for (int j = 0; j < 10; j++) begin
                    step(1'b0, 1'b1, DW'($urandom), 1'b1);
                    if (in_fire || out_fire) frozen_acc++;
                    checks++; if (s_din_ready !== 1'b0) begin errors++; $display("FAIL t6_ready: got %b want 0", s_din_ready); end
                    if (p_hold) begin
                        checks++;
                        if (s_dout_valid !== 1'b1 || s_dout !== p_dout || s_sob !== p_sob || s_eob !== p_eob) begin
                            errors++; $display("FAIL t6_hold: got %0d want %0d", s_dout, p_dout);
                        end
                    end
                end
                checks++; if (frozen_acc != 0) begin errors++; $display("FAIL t6_no_xfer: got %0d want 0", frozen_acc); end
                frozen_acc = 1;
            end
            step(1'b1, sent < 128, DW'($urandom), 1'b1);
            if (in_fire) sent++;
            if (out_fire) begin
                checks++;
                if (!exp_ok || s_dout !== exp_e.val || s_sob !== (exp_e.r == 0) || s_eob !== (exp_e.r == 63)) begin
                    errors++; $display("FAIL t6_data: got dout=%0d want dout=%0d r=%0d queued=%b", s_dout, exp_e.val, exp_e.r, exp_ok);
                end
                outs++;
            end
        end
        checks++; if (outs != 128 || exp_q.size() != 0) begin errors++; $display("FAIL t6_count: got %0d left=%0d want 128 0", outs, exp_q.size()); end
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; din_valid = 1'b0; dout_ready = 1'b0; din = '0;
        build_zz();
        test_reset();
        test_single_block();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_mid_reset();
        test_enable_freeze();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
